// File: rtl/sdram_pro_atref_if.sv
// Auto-refresh engine bus: refresh handshake with the arbiter plus the
// command/address outputs. The ref_miss_cnt signal exists only when
// ATREF_MISS_CNT_EN is defined.
interface sdram_pro_atref_if;
   logic        init_end;
   logic        atref_en;
   logic        atref_req;
   logic [3:0]  atref_cmd;
   logic [1:0]  atref_bank;
   logic [11:0] atref_addr;
   logic        atref_end;
`ifdef ATREF_MISS_CNT_EN
   logic [7:0]  ref_miss_cnt;
`endif

   // Refresh engine side
   modport master (
      input  init_end,
      input  atref_en,
      output atref_req,
      output atref_cmd,
      output atref_bank,
      output atref_addr,
      output atref_end
`ifdef ATREF_MISS_CNT_EN
      , output ref_miss_cnt
`endif
   );

   // Init stage / arbiter side
   modport slave (
      output init_end,
      output atref_en,
      input  atref_req,
      input  atref_cmd,
      input  atref_bank,
      input  atref_addr,
      input  atref_end
`ifdef ATREF_MISS_CNT_EN
      , input ref_miss_cnt
`endif
   );
endinterface

// File: rtl/sdram_pro_atref.sv
// SDRAM auto-refresh engine. After init completes it times the refresh
// interval, requests the bus, and on grant issues PRECHARGE-all followed by
// REF_NUM AUTO_REFRESH commands, then pulses atref_end.
// Optional: define ATREF_MISS_CNT_EN to add the starved-interval counter
// ref_miss_cnt.
module sdram_pro_atref #(
   parameter int CNT_REF_MAX = 749,
   parameter int TRP         = 2,
   parameter int TRC         = 7,
   parameter int REF_NUM     = 2
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   sdram_pro_atref_if.master  atref_bus
);

   localparam int CNT_W   = (CNT_REF_MAX > 0) ? $clog2(CNT_REF_MAX + 1) : 1;
   localparam int CYC_MAX = (TRP > TRC) ? TRP : TRC;
   localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam int REF_W   = (REF_NUM > 1) ? $clog2(REF_NUM) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_REF_MAX);
   localparam logic [CYC_W-1:0] TRP_LAST = CYC_W'(TRP - 1);
   localparam logic [CYC_W-1:0] TRC_LAST = CYC_W'(TRC - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_NUM - 1);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PCH  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PCH  = 2'd1,
      AREF = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_r;
   logic             init_done_r;
   logic [CNT_W-1:0] cnt_ref_r;
   logic             atref_en_d_r;
   logic [CYC_W-1:0] cyc_cnt_r;
   logic [REF_W-1:0] ref_cnt_r;
   logic             atref_req_r;
   logic [3:0]       atref_cmd_r;
   logic             atref_end_r;
   logic             expire_s;
   logic             start_s;

   // Interval expiry and grant rising edge seen while idle
   assign expire_s = (cnt_ref_r == CNT_LAST);
   assign start_s  = atref_bus.atref_en & ~atref_en_d_r & (state_r == IDLE) & init_done_r;

   assign atref_bus.atref_req  = atref_req_r;
   assign atref_bus.atref_cmd  = atref_cmd_r;
   assign atref_bus.atref_bank = 2'b11;
   assign atref_bus.atref_addr = 12'hFFF;
   assign atref_bus.atref_end  = atref_end_r;

   // Sticky init-complete flag and grant edge-detect register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         init_done_r  <= 1'b0;
         atref_en_d_r <= 1'b0;
      end else begin
         if (atref_bus.init_end) begin
            init_done_r <= 1'b1;
         end else begin
            init_done_r <= init_done_r;
         end
         atref_en_d_r <= atref_bus.atref_en;
      end
   end

   // Refresh interval counter, free-running once init is done
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_ref_r <= '0;
      end else if (!init_done_r) begin
         cnt_ref_r <= '0;
      end else if (expire_s) begin
         cnt_ref_r <= '0;
      end else begin
         cnt_ref_r <= cnt_ref_r + CNT_W'(1);
      end
   end

   // Refresh request: set on expiry, cleared on start; expiry takes priority
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         atref_req_r <= 1'b0;
      end else if (expire_s) begin
         atref_req_r <= 1'b1;
      end else if (start_s) begin
         atref_req_r <= 1'b0;
      end else begin
         atref_req_r <= atref_req_r;
      end
   end

   // Refresh sequencer with registered command and done pulse
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= IDLE;
         cyc_cnt_r   <= '0;
         ref_cnt_r   <= '0;
         atref_cmd_r <= CMD_NOP;
         atref_end_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               atref_end_r <= 1'b0;
               if (start_s) begin
                  state_r     <= PCH;
                  cyc_cnt_r   <= '0;
                  atref_cmd_r <= CMD_PCH;
               end else begin
                  atref_cmd_r <= CMD_NOP;
               end
            end
            PCH: begin
               atref_end_r <= 1'b0;
               if (cyc_cnt_r == TRP_LAST) begin
                  state_r     <= AREF;
                  cyc_cnt_r   <= '0;
                  ref_cnt_r   <= '0;
                  atref_cmd_r <= CMD_AREF;
               end else begin
                  cyc_cnt_r   <= cyc_cnt_r + CYC_W'(1);
                  atref_cmd_r <= CMD_NOP;
               end
            end
            AREF: begin
               if (cyc_cnt_r == TRC_LAST) begin
                  cyc_cnt_r <= '0;
                  if (ref_cnt_r == REF_LAST) begin
                     state_r     <= DONE;
                     atref_cmd_r <= CMD_NOP;
                     atref_end_r <= 1'b1;
                  end else begin
                     ref_cnt_r   <= ref_cnt_r + REF_W'(1);
                     atref_cmd_r <= CMD_AREF;
                     atref_end_r <= 1'b0;
                  end
               end else begin
                  cyc_cnt_r   <= cyc_cnt_r + CYC_W'(1);
                  atref_cmd_r <= CMD_NOP;
                  atref_end_r <= 1'b0;
               end
            end
            DONE: begin
               state_r     <= IDLE;
               atref_cmd_r <= CMD_NOP;
               atref_end_r <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               atref_cmd_r <= CMD_NOP;
               atref_end_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef ATREF_MISS_CNT_EN
   logic [7:0] ref_miss_cnt_r;

   assign atref_bus.ref_miss_cnt = ref_miss_cnt_r;

   // Count intervals that expire while the previous request is still pending
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ref_miss_cnt_r <= 8'h00;
      end else if (expire_s && atref_req_r && (ref_miss_cnt_r != 8'hFF)) begin
         ref_miss_cnt_r <= ref_miss_cnt_r + 8'h01;
      end else begin
         ref_miss_cnt_r <= ref_miss_cnt_r;
      end
   end
`endif

endmodule

// File: doc/sdram_pro_atref.md
Name: sdram_pro_atref

Overview:
- Auto-refresh engine for the SDRAM controller; sits directly upstream of the controller's arbiter.
- After initialisation completes, it times the refresh interval and raises atref_req.
- When the arbiter grants the refresh with atref_en, it drives the refresh command sequence (PRECHARGE-all, then REF_NUM AUTO_REFRESH commands) and pulses atref_end when done.
- Command encoding is {cs_n, ras_n, cas_n, we_n}: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001.

Parameters:
CNT_REF_MAX, 749, refresh interval minus 1 in sys_clk cycles (7.5 us at 100 MHz)
TRP, 2, cycles from PRECHARGE to first AUTO_REFRESH (>=1)
TRC, 7, cycles from one AUTO_REFRESH to the next or to atref_end (>=1)
REF_NUM, 2, AUTO_REFRESH commands per sequence (>=1)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  initialisation-complete pulse or level from the init stage
atref_en  in  1  refresh grant from the arbiter (registered level, held through the sequence)
atref_req  out  1  refresh request to the arbiter
atref_cmd  out  4  SDRAM command
atref_bank  out  2  bank address
atref_addr  out  12  address bus
atref_end  out  1  one-cycle sequence-done pulse

Interface (already decided):
- Reset sys_rst_n, asynchronous, active-low; clock sys_clk.

Behaviour:
Reset values:
- atref_req=0, atref_cmd=4'b0111, atref_bank=2'b11, atref_addr=12'hFFF, atref_end=0.
- Internal: init_done=0, interval counter=0, state=IDLE, atref_en_d=0.

Outputs and general rules:
- All outputs are registered.
- atref_bank is constant 2'b11; atref_addr is constant 12'hFFF (A10=1 selects precharge-all).
- init_done is set on the first sampled init_end=1 and is sticky until reset.
- Interval counter: held at 0 while init_done=0. Afterwards it free-runs 0..CNT_REF_MAX and wraps to 0. Its width covers CNT_REF_MAX.

atref_req:
- Set to 1 on the cycle after the counter equals CNT_REF_MAX.
- Cleared on the cycle after start, where start = atref_en & ~atref_en_d & state==IDLE & init_done.
- If set and clear occur on the same cycle, set wins and atref_req stays 1.

State machine: IDLE, PCH, AREF, DONE.
- IDLE: atref_cmd=NOP. Goes to PCH on start.
- PCH: lasts TRP cycles. atref_cmd=PRECHARGE in the first cycle, NOP otherwise. Then goes to AREF.
- AREF: lasts TRC cycles per refresh. atref_cmd=AUTO_REFRESH in the first cycle of each TRC window, NOP otherwise. Repeats REF_NUM windows, tracked by a refresh counter, then goes to DONE.
- DONE: one cycle. atref_end=1, atref_cmd=NOP. Then goes to IDLE.

Latency (cycle 0 = first cycle atref_en is sampled 1):
- PRECHARGE is on cycle 1.
- AUTO_REFRESH k (k=0..REF_NUM-1) is on cycle 1+TRP+k*TRC.
- atref_end is on cycle 1+TRP+REF_NUM*TRC.
- Defaults: PRECHARGE on cycle 1, AUTO_REFRESH on cycles 3 and 10, atref_end on cycle 17.

Boundary conditions:
- atref_en held high after atref_end (the arbiter de-asserts one cycle late) does not restart the sequence. Only a rising edge seen in IDLE starts it.
- atref_en falling mid-sequence: the sequence still completes.
- atref_en rising outside IDLE, or before init_done: ignored.
- init_end re-pulsing after init_done: no effect.
- Reset mid-sequence: every output returns to its reset value immediately; the interval restarts only after a new init_end.

Optional Feature:
- Macro: ATREF_MISS_CNT_EN.
- When defined: adds output ref_miss_cnt [7:0], reset 0. It increments (saturating at 8'hFF) whenever the interval counter equals CNT_REF_MAX while atref_req is already 1, i.e. a refresh interval is starved.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, no init_end for 2000 cycles -> atref_req stays 0; atref_cmd=4'b0111.
- init_end pulse at cycle 10 -> atref_req rises 750 cycles after the counter starts, and every 750 cycles thereafter.
- With atref_req=1, raise atref_en and hold 20 cycles -> PRECHARGE at cycle 1; AUTO_REFRESH at cycles 3 and 10; atref_end pulse at cycle 17 only; atref_req low from cycle 1; no second sequence while atref_en stays high.
- Time atref_en rising to coincide with interval expiry -> atref_req stays 1 (set wins).
- Assert sys_rst_n=0 at cycle 5 of a sequence -> outputs at reset values immediately; no atref_end; no atref_req until a new init_end plus 750 cycles.
- With ATREF_MISS_CNT_EN defined, never grant atref_en for 3 intervals -> ref_miss_cnt reads 2; with the macro undefined the port is absent.
